// File: rtl/mips_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mips_pkg;

  // Arbiter FSM states: idle/arbitrating, or waiting on the RAM for one owner.
  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_IF_BUSY  = 2'd1,
    ARB_MEM_BUSY = 2'd2
  } arb_state_t;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating counter of MEM grants made while IF was left waiting.
module arb_starve_cnt #(
  parameter int unsigned MAX_IF_WAIT = 4,
  localparam int unsigned CNT_W = $clog2(MAX_IF_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic             at_limit_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_IF_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT);
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported unified RAM between the IF and MEM pipeline stages.
// MEM normally wins; IF is forced first after MAX_IF_WAIT consecutive MEM
// grants made while it was waiting. A fetched word is buffered while MEM is
// still outstanding so the same PC is not fetched twice.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_IF_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              ram_req,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              stall,
  output logic              owner
);

  localparam int unsigned CNT_W = $clog2(MAX_IF_WAIT + 1);

  arb_state_t        state_q, state_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic              owner_q, owner_d;
  logic              if_buf_valid_q, if_buf_valid_d;

  logic              mem_pend_s, if_pend_s, force_if_s, done_any_s;
  logic              starve_inc_s, starve_clr_s, at_limit_s;
  logic [CNT_W-1:0]  starve_cnt_s;

  arb_starve_cnt #(.MAX_IF_WAIT(MAX_IF_WAIT)) u_starve (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (starve_inc_s),
    .clr_i      (starve_clr_s),
    .at_limit_o (at_limit_s),
    .cnt_o      (starve_cnt_s)
  );

  // The done pulse masks the request that has just been satisfied.
  assign mem_pend_s = (mem_rd | mem_wr) & ~mem_done_q;
  assign if_pend_s  = if_req & ~if_done_q & ~if_buf_valid_q;
  assign force_if_s = if_pend_s & at_limit_s;
  assign done_any_s = if_done_q | mem_done_q;
  assign stall      = mem_pend_s | if_pend_s;

  // Arbitration, RAM handshake and result capture.
  always_comb begin
    state_d        = state_q;
    ram_req_d      = ram_req_q;
    ram_we_d       = ram_we_q;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    if_rdata_d     = if_rdata_q;
    mem_rdata_d    = mem_rdata_q;
    if_done_d      = 1'b0;
    mem_done_d     = 1'b0;
    owner_d        = owner_q;
    starve_inc_s   = 1'b0;
    starve_clr_s   = 1'b0;
    if_buf_valid_d = (if_buf_valid_q | if_done_q) & stall;
    case (state_q)
      ARB_IDLE: begin
        // No new grant in a done cycle: requests seen there are stale.
        if (!done_any_s && mem_pend_s && !force_if_s) begin
          state_d      = ARB_MEM_BUSY;
          ram_req_d    = 1'b1;
          ram_we_d     = mem_wr;
          ram_addr_d   = mem_addr;
          ram_wdata_d  = mem_wdata;
          owner_d      = OWNER_MEM;
          starve_inc_s = if_pend_s;
        end else if (!done_any_s && if_pend_s) begin
          state_d      = ARB_IF_BUSY;
          ram_req_d    = 1'b1;
          ram_we_d     = 1'b0;
          ram_addr_d   = if_addr;
          owner_d      = OWNER_IF;
          starve_clr_s = 1'b1;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_IF_BUSY: begin
        if (ram_ack) begin
          state_d    = ARB_IDLE;
          ram_req_d  = 1'b0;
          ram_we_d   = 1'b0;
          if_rdata_d = ram_rdata;
          if_done_d  = 1'b1;
        end else begin
          state_d = ARB_IF_BUSY;
        end
      end
      ARB_MEM_BUSY: begin
        if (ram_ack) begin
          state_d    = ARB_IDLE;
          ram_req_d  = 1'b0;
          ram_we_d   = 1'b0;
          mem_done_d = 1'b1;
          if (!ram_we_q) begin
            mem_rdata_d = ram_rdata;
          end else begin
            mem_rdata_d = mem_rdata_q;
          end
        end else begin
          state_d = ARB_MEM_BUSY;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        ram_req_d = 1'b0;
        ram_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ARB_IDLE;
      ram_req_q      <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      if_rdata_q     <= '0;
      mem_rdata_q    <= '0;
      if_done_q      <= 1'b0;
      mem_done_q     <= 1'b0;
      owner_q        <= OWNER_IF;
      if_buf_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ram_req_q      <= ram_req_d;
      ram_we_q       <= ram_we_d;
      ram_addr_q     <= ram_addr_d;
      ram_wdata_q    <= ram_wdata_d;
      if_rdata_q     <= if_rdata_d;
      mem_rdata_q    <= mem_rdata_d;
      if_done_q      <= if_done_d;
      mem_done_q     <= mem_done_d;
      owner_q        <= owner_d;
      if_buf_valid_q <= if_buf_valid_d;
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_IF_WAIT = 2).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_rd, mem_wr, ram_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_done, mem_done, ram_req, ram_we, stall, owner;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.DATA_W(32), .MAX_IF_WAIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stall(stall), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to the middle of the next cycle (2 time units after the rising edge).
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; ram_ack = 1'b0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; ram_rdata = 32'h0;
    cyc(); cyc(); #1;
    chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_buf", {31'd0, dut.if_buf_valid_q}, 32'd0);
    chk("rst_cnt", 32'(dut.starve_cnt_s), 32'd0);
    rst = 1'b1;

    // IF only, ack two cycles after ram_req.
    cyc(); if_req = 1'b1; if_addr = 32'h40; #1;
    chk("if_stall", {31'd0, stall}, 32'd1);
    cyc(); #1;
    chk("if_req", {31'd0, ram_req}, 32'd1);
    chk("if_addr", ram_addr, 32'h40);
    chk("if_we", {31'd0, ram_we}, 32'd0);
    chk("if_owner", {31'd0, owner}, 32'd0);
    cyc();
    cyc(); ram_ack = 1'b1; ram_rdata = 32'h8C220004; #1;
    chk("if_req_held", {31'd0, ram_req}, 32'd1);
    cyc(); ram_ack = 1'b0; #1;
    chk("if_done", {31'd0, if_done}, 32'd1);
    chk("if_rdata", if_rdata, 32'h8C220004);
    chk("if_stall_drop", {31'd0, stall}, 32'd0);
    chk("if_req_drop", {31'd0, ram_req}, 32'd0);
    if_req = 1'b0;
    cyc(); #1;
    chk("if_done_pulse", {31'd0, if_done}, 32'd0);
    chk("if_buf", {31'd0, dut.if_buf_valid_q}, 32'd0);

    // Collision: MEM first, then IF.
    cyc(); if_req = 1'b1; if_addr = 32'h44; mem_rd = 1'b1; mem_addr = 32'h100; #1;
    chk("col_stall", {31'd0, stall}, 32'd1);
    cyc(); #1;
    chk("col_owner_mem", {31'd0, owner}, 32'd1);
    chk("col_addr_mem", ram_addr, 32'h100);
    chk("col_cnt1", 32'(dut.starve_cnt_s), 32'd1);
    cyc(); ram_ack = 1'b1; ram_rdata = 32'h11;
    cyc(); ram_ack = 1'b0; #1;
    chk("col_mem_done", {31'd0, mem_done}, 32'd1);
    chk("col_mem_rdata", mem_rdata, 32'h11);
    chk("col_stall_if", {31'd0, stall}, 32'd1);
    mem_rd = 1'b0;
    cyc(); #1;
    chk("col_no_grant_yet", {31'd0, ram_req}, 32'd0);
    cyc(); #1;
    chk("col_owner_if", {31'd0, owner}, 32'd0);
    chk("col_addr_if", ram_addr, 32'h44);
    chk("col_req_if", {31'd0, ram_req}, 32'd1);
    chk("col_cnt0", 32'(dut.starve_cnt_s), 32'd0);
    ram_ack = 1'b1; ram_rdata = 32'h22;
    cyc(); ram_ack = 1'b0; #1;
    chk("col_if_done", {31'd0, if_done}, 32'd1);
    chk("col_if_rdata", if_rdata, 32'h22);
    chk("col_mem_keep", mem_rdata, 32'h11);
    chk("col_stall_end", {31'd0, stall}, 32'd0);
    if_req = 1'b0;
    cyc(); #1;
    chk("col_buf", {31'd0, dut.if_buf_valid_q}, 32'd0);

    // Store with same-cycle ack.
    cyc(); mem_wr = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
    cyc(); ram_ack = 1'b1; #1;
    chk("st_req", {31'd0, ram_req}, 32'd1);
    chk("st_we", {31'd0, ram_we}, 32'd1);
    chk("st_addr", ram_addr, 32'h200);
    chk("st_wdata", ram_wdata, 32'hDEADBEEF);
    cyc(); ram_ack = 1'b0; #1;
    chk("st_req_1cyc", {30'd0, ram_req, ram_we}, 32'd0);
    chk("st_done", {31'd0, mem_done}, 32'd1);
    chk("st_rdata_keep", mem_rdata, 32'h11);
    chk("st_stall", {31'd0, stall}, 32'd0);
    mem_wr = 1'b0;
    cyc(); #1;
    chk("st_done_pulse", {31'd0, mem_done}, 32'd0);

    // Starvation: MEM, MEM, then IF forced; fetched word buffered.
    cyc(); if_req = 1'b1; if_addr = 32'h48; mem_rd = 1'b1; mem_addr = 32'h300;
    cyc(); #1;
    chk("sv_g1_owner", {31'd0, owner}, 32'd1);
    chk("sv_g1_addr", ram_addr, 32'h300);
    ram_ack = 1'b1; ram_rdata = 32'hA1;
    cyc(); ram_ack = 1'b0; mem_addr = 32'h304; #1;
    chk("sv_g1_rdata", mem_rdata, 32'hA1);
    chk("sv_cnt1", 32'(dut.starve_cnt_s), 32'd1);
    cyc();
    cyc(); #1;
    chk("sv_g2_owner", {31'd0, owner}, 32'd1);
    chk("sv_g2_addr", ram_addr, 32'h304);
    ram_ack = 1'b1; ram_rdata = 32'hA2;
    cyc(); ram_ack = 1'b0; mem_addr = 32'h308; #1;
    chk("sv_g2_rdata", mem_rdata, 32'hA2);
    chk("sv_cnt2", 32'(dut.starve_cnt_s), 32'd2);
    cyc();
    cyc(); #1;
    chk("sv_g3_owner_if", {31'd0, owner}, 32'd0);
    chk("sv_g3_addr", ram_addr, 32'h48);
    chk("sv_cnt_clr", 32'(dut.starve_cnt_s), 32'd0);
    ram_ack = 1'b1; ram_rdata = 32'h1234;
    cyc(); ram_ack = 1'b0; #1;
    chk("sv_if_done", {31'd0, if_done}, 32'd1);
    chk("sv_stall_mem", {31'd0, stall}, 32'd1);
    cyc(); #1;
    chk("sv_buf_set", {31'd0, dut.if_buf_valid_q}, 32'd1);
    chk("sv_buf_stall", {31'd0, stall}, 32'd1);
    cyc(); #1;
    chk("sv_g4_owner", {31'd0, owner}, 32'd1);
    chk("sv_g4_addr", ram_addr, 32'h308);
    chk("sv_if_hold", if_rdata, 32'h1234);
    chk("sv_cnt_hold", 32'(dut.starve_cnt_s), 32'd0);
    ram_ack = 1'b1; ram_rdata = 32'hA3;
    cyc(); ram_ack = 1'b0; #1;
    chk("sv_g4_done", {31'd0, mem_done}, 32'd1);
    chk("sv_g4_rdata", mem_rdata, 32'hA3);
    chk("sv_stall_clr", {31'd0, stall}, 32'd0);
    mem_rd = 1'b0; if_req = 1'b0;
    cyc(); #1;
    chk("sv_no_refetch", {31'd0, ram_req}, 32'd0);
    chk("sv_buf_clr", {31'd0, dut.if_buf_valid_q}, 32'd0);

    // Reset in the middle of a MEM access.
    cyc(); mem_rd = 1'b1; mem_addr = 32'h400;
    cyc(); #1;
    chk("rm_req", {31'd0, ram_req}, 32'd1);
    rst = 1'b0; #1;
    chk("rm_req_drop", {31'd0, ram_req}, 32'd0);
    chk("rm_owner", {31'd0, owner}, 32'd0);
    chk("rm_addr", ram_addr, 32'h0);
    chk("rm_mem_rdata", mem_rdata, 32'h0);
    chk("rm_if_rdata", if_rdata, 32'h0);
    cyc(); ram_ack = 1'b1; ram_rdata = 32'h99; rst = 1'b1;
    cyc(); ram_ack = 1'b0; #1;
    chk("rm_ack_ignored", {31'd0, mem_done}, 32'd0);
    chk("rm_rdata_ignored", mem_rdata, 32'h0);
    chk("rm_reissue_req", {31'd0, ram_req}, 32'd1);
    chk("rm_reissue_addr", ram_addr, 32'h400);
    cyc(); ram_ack = 1'b1; ram_rdata = 32'h55;
    cyc(); ram_ack = 1'b0; #1;
    chk("rm_done", {31'd0, mem_done}, 32'd1);
    chk("rm_rdata", mem_rdata, 32'h55);
    mem_rd = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (lw/sw from the EXE/MEM pipeline register outputs). Runs a 3-state FSM around a req/ack RAM handshake, gives the MEM stage priority, and guards IF against starvation. Drives one global stall that freezes PC, IF/ID, ID/EX and EXE/MEM until both stages have their access. MEM/WB loads a bubble while stall=1.

Parameters:
DATA_W, 32, data/address width
MAX_IF_WAIT, 4, consecutive MEM grants with IF pending before IF is forced first (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
if_req  in  1  IF stage wants the instruction at if_addr
if_addr  in  DATA_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction word, registered
if_done  out  1  one-cycle pulse: if_rdata valid for current PC
mem_rd  in  1  EXE/MEM mem_read
mem_wr  in  1  EXE/MEM mem_write
mem_addr  in  DATA_W  EXE/MEM ALU result
mem_wdata  in  DATA_W  EXE/MEM store data
mem_rdata  out  DATA_W  load data, registered
mem_done  out  1  one-cycle pulse: load/store complete
ram_req  out  1  RAM request, held until ram_ack
ram_we  out  1  1 = write
ram_addr  out  DATA_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid with ram_ack
ram_ack  in  1  RAM completion, may arrive in the first ram_req cycle
stall  out  1  global pipeline freeze, combinational
owner  out  1  0 = IF, 1 = MEM; current/last grant

Behaviour:
- Reset (rst=0, async): state IDLE; ram_req, ram_we, ram_addr, ram_wdata, if_rdata, mem_rdata, if_done, mem_done, owner, if_buf_valid, starve_cnt all 0. Any transaction in flight is aborted: ram_req drops immediately, and the ack is ignored.
- Pending terms: mem_pend = (mem_rd|mem_wr) & ~mem_done; if_pend = if_req & ~if_done & ~if_buf_valid.
- stall = mem_pend | if_pend.
- States:
  - IDLE: no request pending -> stay.
    - force_if = if_pend & (starve_cnt == MAX_IF_WAIT).
    - mem_pend & ~force_if -> MEM_BUSY. Latch ram_addr=mem_addr, ram_we=mem_wr, ram_wdata=mem_wdata, ram_req=1, owner=1.
    - Else if_pend -> IF_BUSY. Latch ram_addr=if_addr, ram_we=0, ram_req=1, owner=0.
  - IF_BUSY / MEM_BUSY: hold all ram_* outputs stable until ram_ack. On ram_ack:
    - ram_req=0, ram_we=0, next state IDLE.
    - Owner's rdata register <= ram_rdata. For writes, mem_rdata is unchanged.
    - Owner's done = 1 on the next cycle only.
- Timing: request seen in IDLE at T; ram_req visible T+1; ack at A>=T+1; done and data at A+1. Requests seen in the done cycle are the old (satisfied) ones and are masked by the done term. New arbitration happens at A+2 at the earliest. Back-to-back accesses therefore cost >=3 cycles each.
- IF buffer: if_buf_valid_next = (if_buf_valid | if_done) & stall. This holds a fetched word while MEM is still pending and blocks a refetch of the same PC. It clears on the first cycle with stall=0. if_rdata holds its value while if_buf_valid.
- Starvation:
  - starve_cnt increments (saturating at MAX_IF_WAIT) on each MEM grant made while if_pend=1.
  - Clears to 0 on any IF grant.
  - Holds on a MEM grant with IF idle.
- Simultaneous if_pend & mem_pend, counter below limit: MEM wins (older instruction).
- mem_rd & mem_wr both 1: treated as a write.
- Requests changing while BUSY are ignored; the latched values are used.

Decomposition:
- mips_pkg: arb_state_t enum {ARB_IDLE, ARB_IF_BUSY, ARB_MEM_BUSY}; constants OWNER_IF=1'b0, OWNER_MEM=1'b1.
- One natural sub-module, arb_starve_cnt. It holds the saturating counter with inc/clr inputs and an at_limit output, parameterised by MAX_IF_WAIT.

Test Plan:
- IF only: if_req=1, if_addr=0x40; RAM acks 2 cycles after ram_req with 0x8C220004 -> ram_addr=0x40, ram_we=0; if_done pulses 1 cycle after ack with if_rdata=0x8C220004; stall drops that same cycle.
- Collision: if_req=1 (0x44) and mem_rd=1 (0x100) at T; ack in 1 cycle with 0x11 then 0x22 -> MEM served first, then IF. mem_rdata=0x11 and if_rdata=0x22; stall=1 until IF done; if_buf_valid not set, since stall clears at if_done.
- IF-first buffer: MAX_IF_WAIT=1, starve_cnt=1, if_req and mem_rd both pending -> IF granted first. if_buf_valid=1 and if_rdata held while MEM is served; stall=1 until mem_done; no second fetch of the same PC.
- Store: mem_wr=1, addr 0x200, wdata 0xDEADBEEF, same-cycle ack -> ram_req/ram_we for exactly 1 cycle with 0x200/0xDEADBEEF; mem_done pulses; mem_rdata unchanged.
- Starvation: MAX_IF_WAIT=2, mem_rd renewed after every mem_done with if_req held -> grants MEM, MEM, IF; starve_cnt returns to 0.
- Reset mid-op: rst=0 during MEM_BUSY before ack -> ram_req=0 and all outputs 0 immediately. A later ack is ignored; after rst=1, IDLE re-arbitrates and reissues the pending load.
